rtc_core_param: RTL

Parametrised HH:MM:SS:CS real-time clock core, the successor of the lab-5 presettable clock. It has a generic clock-to-tick divider and a single-cycle carry chain with no derived clocks. Per-field BCD preset with range saturation, 12/24-hour display mode and a sticky HH:MM alarm are included. It sits between the board switches/keys and the two-digit HEX display drivers.

---
 rtl/rtc_core_param_pkg.sv | 16 +
 rtl/rtc_bin2bcd2.sv | 16 +
 rtl/rtc_core_param.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rtc_core_param_pkg.sv
// Shared constants for the HH:MM:SS:CS real-time clock core.
package rtc_core_param_pkg;

    localparam logic [6:0] CS_MAX = 7'd99;
    localparam logic [6:0] SS_MAX = 7'd59;
    localparam logic [6:0] MM_MAX = 7'd59;
    localparam logic [6:0] HH_MAX = 7'd23;

    typedef enum logic [1:0] {
        SEL_CS = 2'd0,
        SEL_SS = 2'd1,
        SEL_MM = 2'd2,
        SEL_HH = 2'd3
    } ld_sel_t;

endpackage

// File: rtl/rtc_bin2bcd2.sv
// Binary 0..99 to two-digit BCD {tens,units} for the display outputs.
module rtc_bin2bcd2 (
    input  logic [6:0] bin,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        tens = 4'(bin / 7'd10);
        units = 4'(bin % 7'd10);
        bcd = {tens, units};
    end

endmodule

// File: rtl/rtc_core_param.sv
// Real-time clock core: clock-to-centisecond divider, single-edge carry chain,
// saturating BCD presets, 12/24-hour display and sticky HH:MM alarm.
module rtc_core_param
    import rtc_core_param_pkg::*;
#(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100,
    parameter int DIV_W   = 20
) (
    input  logic       Clk,
    input  logic       Clrn,
    input  logic       En,
    input  logic       Ld,
    input  logic [1:0] Ld_Sel,
    input  logic       Ld_Alm,
    input  logic [7:0] Ld_Bcd,
    input  logic       Mode12,
    input  logic       Alm_En,
    input  logic       Alm_Clr,
    output logic [7:0] Bcd_HH,
    output logic [7:0] Bcd_MM,
    output logic [7:0] Bcd_SS,
    output logic [7:0] Bcd_CS,
    output logic       Pm,
    output logic       Tick,
    output logic       Sec_P,
    output logic       Min_P,
    output logic       Alarm
);

    localparam int D = CLK_HZ / TICK_HZ;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(D - 1);

    logic [DIV_W-1:0] div_reg, div_next;
    logic [6:0] cs_reg, cs_next, ss_reg, ss_next, mm_reg, mm_next, hh_reg, hh_next;
    logic [6:0] alm_mm_reg, alm_mm_next, alm_hh_reg, alm_hh_next;
    logic       tick_reg, sec_p_reg, sec_p_next, min_p_reg, min_p_next;
    logic       alarm_reg, alarm_next;

    logic       wrap, cs_carry, ss_carry, mm_carry;
    logic       ld_time, ld_alm, ld_cs, ld_ss, ld_mm, ld_hh, alarm_set;
    logic [6:0] ld_max, ld_val, hh_disp;
    ld_sel_t    sel;

    // Any non-decimal digit or out-of-range value saturates to the field maximum.
    function automatic logic [6:0] bcd_sat(input logic [7:0] bcd, input logic [6:0] max);
        logic [6:0] v;
        if (bcd[7:4] > 4'd9 || bcd[3:0] > 4'd9)
            return max;
        v = 7'(bcd[7:4]) * 7'd10 + 7'(bcd[3:0]);
        return (v > max) ? max : v;
    endfunction

    always_comb begin
        sel = ld_sel_t'(Ld_Sel);
        case (sel)
            SEL_CS:  ld_max = CS_MAX;
            SEL_SS:  ld_max = SS_MAX;
            SEL_MM:  ld_max = MM_MAX;
            default: ld_max = HH_MAX;
        endcase
        ld_val  = bcd_sat(Ld_Bcd, ld_max);
        ld_time = Ld && !Ld_Alm;
        ld_alm  = Ld && Ld_Alm;
        ld_cs   = ld_time && (sel == SEL_CS);
        ld_ss   = ld_time && (sel == SEL_SS);
        ld_mm   = ld_time && (sel == SEL_MM);
        ld_hh   = ld_time && (sel == SEL_HH);

        // Carries are decided from current field values so every field moves on one edge.
        wrap     = En && (div_reg == DIV_LAST);
        cs_carry = wrap && (cs_reg == CS_MAX);
        ss_carry = cs_carry && (ss_reg == SS_MAX);
        mm_carry = ss_carry && (mm_reg == MM_MAX);

        if (ld_cs || wrap)
            div_next = '0;
        else if (En)
            div_next = div_reg + 1'b1;
        else
            div_next = div_reg;

        cs_next = ld_cs ? ld_val : (wrap     ? (cs_carry ? 7'd0 : cs_reg + 7'd1) : cs_reg);
        ss_next = ld_ss ? ld_val : (cs_carry ? (ss_carry ? 7'd0 : ss_reg + 7'd1) : ss_reg);
        mm_next = ld_mm ? ld_val : (ss_carry ? (mm_carry ? 7'd0 : mm_reg + 7'd1) : mm_reg);
        hh_next = ld_hh ? ld_val : (mm_carry ? ((hh_reg == HH_MAX) ? 7'd0 : hh_reg + 7'd1) : hh_reg);

        alm_mm_next = (ld_alm && sel == SEL_MM) ? ld_val : alm_mm_reg;
        alm_hh_next = (ld_alm && sel == SEL_HH) ? ld_val : alm_hh_reg;

        sec_p_next = cs_carry && !ld_ss;
        min_p_next = ss_carry && !ld_mm;

        alarm_set  = Alm_En && ss_carry && !ld_ss &&
                     (hh_next == alm_hh_reg) && (mm_next == alm_mm_reg);
        alarm_next = alarm_set || (alarm_reg && Alm_En && !Alm_Clr);
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            div_reg    <= '0;
            cs_reg     <= '0;
            ss_reg     <= '0;
            mm_reg     <= '0;
            hh_reg     <= '0;
            alm_mm_reg <= '0;
            alm_hh_reg <= '0;
            tick_reg   <= 1'b0;
            sec_p_reg  <= 1'b0;
            min_p_reg  <= 1'b0;
            alarm_reg  <= 1'b0;
        end else begin
            div_reg    <= div_next;
            cs_reg     <= cs_next;
            ss_reg     <= ss_next;
            mm_reg     <= mm_next;
            hh_reg     <= hh_next;
            alm_mm_reg <= alm_mm_next;
            alm_hh_reg <= alm_hh_next;
            tick_reg   <= wrap;
            sec_p_reg  <= sec_p_next;
            min_p_reg  <= min_p_next;
            alarm_reg  <= alarm_next;
        end
    end

    always_comb begin
        if (!Mode12)
            hh_disp = hh_reg;
        else if (hh_reg == 7'd0)
            hh_disp = 7'd12;
        else if (hh_reg > 7'd12)
            hh_disp = hh_reg - 7'd12;
        else
            hh_disp = hh_reg;
    end

    logic [6:0] fld [4];
    logic [7:0] bcd [4];

    assign fld[0] = cs_reg;
    assign fld[1] = ss_reg;
    assign fld[2] = mm_reg;
    assign fld[3] = hh_disp;

    for (genvar gi = 0; gi < 4; gi++) begin : g_disp
        rtc_bin2bcd2 u_bcd (
            .bin (fld[gi]),
            .bcd (bcd[gi])
        );
    end

    assign Bcd_CS = bcd[0];
    assign Bcd_SS = bcd[1];
    assign Bcd_MM = bcd[2];
    assign Bcd_HH = bcd[3];
    assign Pm     = (hh_reg >= 7'd12);
    assign Tick   = tick_reg;
    assign Sec_P  = sec_p_reg;
    assign Min_P  = min_p_reg;
    assign Alarm  = alarm_reg;

endmodule
